load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 5, word-address width of the data memory; byte address is ADDR_W+3 bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ_VALID  input  1  request present.
REQ-005 REQ_READY  output  1  unit accepts request; high only in IDLE.
REQ-006 REQ_WE  input  1  1 = store, 0 = load.
REQ-007 REQ_SIZE  input  2  0 byte, 1 half, 2 word, 3 doubleword.
REQ-008 REQ_UNSIGNED  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 REQ_ADDR  input  ADDR_W+3  byte address.
REQ-010 REQ_WDATA  input  64  store data, right-aligned.
REQ-011 RSP_VALID  output  1  one-cycle completion pulse.
REQ-012 RSP_RDATA  output  64  extended load data; valid with RSP_VALID on loads, 0 on stores.
REQ-013 RSP_ERR  output  1  misaligned request rejected (LSU_MISALIGN_TRAP_EN only; else constant 0).
REQ-014 MEM_ADDR  output  ADDR_W  word address to datamemory ADDR.
REQ-015 MEM_WE  output  1  datamemory WE.
REQ-016 MEM_DIN  output  64  datamemory D_in.
REQ-017 MEM_DOUT  input  64  datamemory D_out; combinational read of MEM_ADDR, write on CLK rising edge when MEM_WE.

Function
REQ-018 FSM states IDLE, READ, WRITE, RESP; request accepted and registered on the edge where state is IDLE and REQ_VALID is 1.
REQ-019 From IDLE: load -> READ; doubleword store -> WRITE; sub-doubleword store -> READ.
REQ-020 READ: MEM_WE=0, MEM_DOUT captured at end of cycle; load -> RESP, store -> WRITE.
REQ-021 WRITE: MEM_WE=1 for exactly one cycle, MEM_DIN = captured word with the selected byte lanes replaced by REQ_WDATA low bytes (full word for size 3); -> RESP.
REQ-022 RESP: RSP_VALID=1 for one cycle, no backpressure; -> IDLE; a new request may be accepted in the following cycle.
REQ-023 Latency from accept edge to RSP_VALID: load 2 cycles, doubleword store 2, sub-doubleword store 3.
REQ-024 Byte lane = REQ_ADDR[2:0] (little-endian); MEM_ADDR = REQ_ADDR[ADDR_W+2:3], held from the registered request outside IDLE, 0 in IDLE.
REQ-025 Load extraction: lane field shifted to bit 0, extended per REQ_UNSIGNED to 64 bits; size 3 returns full word.
REQ-026 MEM_WE is 0 in every state except WRITE; MEM_DIN is 0 outside WRITE.
REQ-027 REQ_VALID held while not in IDLE is ignored; requests are never queued.

Reset
REQ-028 RST_N low forces immediately: state IDLE, REQ_READY 1, RSP_VALID 0, RSP_RDATA 0, RSP_ERR 0, MEM_WE 0, MEM_ADDR 0, MEM_DIN 0, all registers 0.
REQ-029 Reset during READ/WRITE/RESP aborts the operation; no response issued; a write is performed only if MEM_WE was high at a rising edge while RST_N was high.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: request with REQ_ADDR not a multiple of 2^REQ_SIZE goes IDLE -> RESP (RSP_VALID 1 cycle after accept), RSP_ERR=1, RSP_RDATA=0, no memory access.
REQ-031 Macro undefined: offset bits below the size alignment are cleared (address aligned down), RSP_ERR tied to 0, no error path.

Structure
REQ-032 Package lsu_pkg holds state enum (IDLE, READ, WRITE, RESP) and size constants SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3.
REQ-033 One combinational sub-module lsu_byte_lane: load extract/extend and store merge; FSM and registers stay in load_store_unit.

Verification
REQ-034 Store D 150 at byte addr 0x58 -> MEM_WE high one cycle with MEM_ADDR 11, MEM_DIN 150; RSP_VALID 2 cycles after accept.
REQ-035 Word 11 = 0x1122334455667788, store B 0xAB at 0x5A -> READ then WRITE MEM_DIN 0x1122334455AB7788; RSP_VALID 3 cycles after accept.
REQ-036 Word 11 = 0x00000000000080FF, load H signed at 0x58 -> RSP_RDATA 0xFFFFFFFFFFFF80FF; unsigned -> 0x00000000000080FF; RSP_VALID 2 cycles after accept.
REQ-037 RST_N low during WRITE cycle -> MEM_WE drops immediately, memory word unchanged, no RSP_VALID, REQ_READY 1.
REQ-038 With LSU_MISALIGN_TRAP_EN, load W at 0x5A -> RSP_ERR 1, RSP_RDATA 0, MEM_WE never high; without macro same request returns word at 0x58.
REQ-039 Back-to-back: REQ_VALID held high with two loads -> second accepted the cycle after first RSP_VALID, REQ_READY 0 in between.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// access-size codes and the per-size masks used by the lane logic.
package lsu_pkg;

  // Sequencer states of the load/store unit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Access size codes carried on req_size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Byte-offset bits that must be zero for an access of this size to be aligned
  function automatic logic [2:0] offset_mask(input logic [1:0] size);
    case (size)
      SZ_B:    offset_mask = 3'b000;
      SZ_H:    offset_mask = 3'b001;
      SZ_W:    offset_mask = 3'b011;
      default: offset_mask = 3'b111;
    endcase
  endfunction

  // Right-aligned mask covering all bits of an access of this size
  function automatic logic [63:0] field_mask(input logic [1:0] size);
    case (size)
      SZ_B:    field_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    field_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    field_mask = 64'h0000_0000_FFFF_FFFF;
      default: field_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Bit index of the sign bit of a right-aligned field of this size
  function automatic logic [5:0] field_msb(input logic [1:0] size);
    case (size)
      SZ_B:    field_msb = 6'd7;
      SZ_H:    field_msb = 6'd15;
      SZ_W:    field_msb = 6'd31;
      default: field_msb = 6'd63;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane datapath of the load/store unit.
// Load side: pulls the addressed field out of a memory word, moves it to
// bit 0 and sign- or zero-extends it to 64 bits.
// Store side: merges the low bytes of the store data into the addressed
// byte lanes of a memory word, leaving the other lanes untouched.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [2:0]  lane,
  input  logic [63:0] word,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_word
);

  logic [5:0]  shamt;
  logic [63:0] fmask;
  logic [63:0] lane_mask;
  logic [63:0] shifted;
  logic        sign_bit;

  // Load extraction/extension and store merge for the selected lanes
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    load_data  = '0;
    store_word = '0;
    shamt      = {lane, 3'b000};
    fmask      = field_mask(size);
    lane_mask  = fmask << shamt;
    shifted    = (word >> shamt) & fmask;
    sign_bit   = shifted[field_msb(size)] & ~is_unsigned;

    load_data  = sign_bit ? (shifted | ~fmask) : shifted;
    store_word = (word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a single-port 64-bit data memory with a
// combinational read port and a clocked write port.
// Sub-doubleword stores are done as read-modify-write (READ then WRITE);
// loads take one READ cycle; every request finishes with one RESP cycle.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned requests
// with rsp_err instead of silently aligning the address down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+2:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [63:0]       mem_din,
  input  logic [63:0]       mem_dout
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [2:0]  lane_q;
  logic [63:0] wdata_q;

  logic        accept;
  logic        misaligned;
  logic [2:0]  aligned_lane;
  logic [63:0] load_data;
  logic [63:0] store_word;

  assign accept       = (state_q == IDLE) && req_valid;
  assign aligned_lane = req_addr[2:0] & ~offset_mask(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = |(req_addr[2:0] & offset_mask(req_size));
`else
  assign misaligned = 1'b0;
`endif

  lsu_byte_lane u_byte_lane (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .lane        (lane_q),
    .word        (mem_dout),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // Request sequencer with registered request fields and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      unsigned_q <= 1'b0;
      lane_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // in this block sees the pre-edge values, independent of statement order.
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            lane_q     <= aligned_lane;
            wdata_q    <= req_wdata;
            mem_addr   <= req_addr[ADDR_W+2:3];
            req_ready  <= 1'b0;
            if (misaligned) begin
              // Rejected: straight to the response, memory untouched
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we && (req_size == SZ_D)) begin
              // Whole-word store needs no read-back
              state_q <= WRITE;
              mem_we  <= 1'b1;
              mem_din <= req_wdata;
            end else begin
              state_q <= READ;
            end
          end
        end

        READ: begin
          if (we_q) begin
            state_q <= WRITE;
            mem_we  <= 1'b1;
            mem_din <= store_word;
          end else begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end

        WRITE: begin
          state_q   <= RESP;
          mem_we    <= 1'b0;
          mem_din   <= '0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end

        RESP: begin
          state_q   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          mem_addr  <= '0;
          req_ready <= 1'b1;
        end

        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  // Error flag: set on accepting a misaligned request, cleared after RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misaligned;
    end else if (state_q == RESP) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// loads/stores compared against a byte-level reference memory model.
module tb_load_store_unit;

  localparam int ADDR_W = 5;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+2:0] req_addr;
  logic [63:0]       req_wdata;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [63:0]       mem_din;
  logic [63:0]       mem_dout;

  // Data memory attached to the unit, plus a backdoor write port for setup
  logic [63:0]       dmem [NWORDS];
  logic              bd_we = 1'b0;
  logic [ADDR_W-1:0] bd_idx = '0;
  logic [63:0]       bd_data = '0;

  // Reference memory kept by the model
  logic [63:0]       ref_mem [NWORDS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_dout = dmem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_din;
    else if (bd_we) dmem[bd_idx] <= bd_data;
  end

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // Behavioural model: byte-granular access on ref_mem
  function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [7:0] addr, input logic [63:0] wdata,
                                    output logic [63:0] rdata, output logic err, output int lat);
    int nbytes, widx, off;
    logic [63:0] val;
    nbytes = 1 << size;
    widx   = int'(addr) / 8;
    off    = int'(addr) % 8;
    rdata  = '0;
    err    = 1'b0;
    lat    = 0;
    if (off % nbytes != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      err = 1'b1;
      lat = 1;
      return;
`else
      off = off - (off % nbytes);
`endif
    end
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[widx][8*(off+i) +: 8] = wdata[8*i +: 8];
      lat = (nbytes == 8) ? 2 : 3;
    end else begin
      val = '0;
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[widx][8*(off+i) +: 8];
      if (!uns && nbytes < 8 && val[8*nbytes-1])
        for (int i = nbytes; i < 8; i++) val[8*i +: 8] = 8'hFF;
      rdata = val;
      lat   = 2;
    end
  endfunction

  task automatic bd_write(input int idx, input logic [63:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx[ADDR_W-1:0]; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Issue one request and observe it until the response (bounded)
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [63:0] wdata,
                         output int lat, output logic [63:0] rdata, output logic err,
                         output int we_cyc, output logic [ADDR_W-1:0] wr_addr,
                         output logic [63:0] wr_din, output logic ready_ok);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    ready_ok = 1'b1;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) ready_ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; we_cyc = 0; rdata = '0; err = 1'b0; wr_addr = '0; wr_din = '0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cyc++;
        wr_addr = mem_addr;
        wr_din  = mem_din;
      end
      if (req_ready) ready_ok = 1'b0;
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        err   = rsp_err;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rsp_err); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
    checks++; if (mem_din !== 64'd0) begin errors++; $display("FAIL reset_mem_din got %h want 0", mem_din); end
  endtask

  task automatic test_store_d();
    int lat, wc; logic [63:0] rd, din, erd; logic er, eer, rok; logic [ADDR_W-1:0] wa; int elat;
    model_req(1'b1, 2'd3, 1'b0, 8'h58, 64'd150, erd, eer, elat);
    run_req(1'b1, 2'd3, 1'b0, 8'h58, 64'd150, lat, rd, er, wc, wa, din, rok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL std_latency got %0d want 2", lat); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL std_we_cycles got %0d want 1", wc); end
    checks++; if (wa !== 5'd11) begin errors++; $display("FAIL std_mem_addr got %0d want 11", wa); end
    checks++; if (din !== 64'd150) begin errors++; $display("FAIL std_mem_din got %h want 96", din); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL std_rdata got %h want 0", rd); end
    checks++; if (!rok) begin errors++; $display("FAIL std_ready got high-while-busy want low"); end
  endtask

  task automatic test_store_b_rmw();
    int lat, wc; logic [63:0] rd, din, erd; logic er, eer, rok; logic [ADDR_W-1:0] wa; int elat;
    bd_write(11, 64'h1122334455667788);
    model_req(1'b1, 2'd0, 1'b0, 8'h5A, 64'hAB, erd, eer, elat);
    run_req(1'b1, 2'd0, 1'b0, 8'h5A, 64'hAB, lat, rd, er, wc, wa, din, rok);
    checks++; if (lat !== 3) begin errors++; $display("FAIL stb_latency got %0d want 3", lat); end
    checks++; if (din !== 64'h1122334455AB7788) begin errors++; $display("FAIL stb_mem_din got %h want 1122334455ab7788", din); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL stb_we_cycles got %0d want 1", wc); end
    checks++; if (dmem[11] !== 64'h1122334455AB7788) begin errors++; $display("FAIL stb_mem_word got %h want 1122334455ab7788", dmem[11]); end
  endtask

  task automatic test_load_h_ext();
    int lat, wc; logic [63:0] rd, din; logic er, rok; logic [ADDR_W-1:0] wa;
    bd_write(11, 64'h00000000000080FF);
    run_req(1'b0, 2'd1, 1'b0, 8'h58, 64'd0, lat, rd, er, wc, wa, din, rok);
    checks++; if (rd !== 64'hFFFFFFFFFFFF80FF) begin errors++; $display("FAIL ldh_signed got %h want ffffffffffff80ff", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL ldh_latency got %0d want 2", lat); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL ldh_we_cycles got %0d want 0", wc); end
    run_req(1'b0, 2'd1, 1'b1, 8'h58, 64'd0, lat, rd, er, wc, wa, din, rok);
    checks++; if (rd !== 64'h00000000000080FF) begin errors++; $display("FAIL ldh_unsigned got %h want 80ff", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL ldhu_latency got %0d want 2", lat); end
  endtask

  task automatic test_reset_in_write();
    int seen;
    bd_write(11, 64'hCAFEF00D12345678);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 8'h58; req_wdata = 64'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstw_in_write got mem_we %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstw_mem_we got %b want 0", mem_we); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready got %b want 1", req_ready); end
    checks++; if (mem_din !== 64'd0) begin errors++; $display("FAIL rstw_mem_din got %h want 0", mem_din); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstw_rsp_valid got %0d pulses want 0", seen); end
    checks++; if (dmem[11] !== 64'hCAFEF00D12345678) begin errors++; $display("FAIL rstw_mem_word got %h want cafef00d12345678", dmem[11]); end
  endtask

  task automatic test_misaligned();
    int lat, wc; logic [63:0] rd, din; logic er, rok; logic [ADDR_W-1:0] wa;
    bd_write(11, 64'h1122334455667788);
    run_req(1'b0, 2'd2, 1'b0, 8'h5A, 64'd0, lat, rd, er, wc, wa, din, rok);
    checks++; if (wc !== 0) begin errors++; $display("FAIL mis_we_cycles got %0d want 0", wc); end
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", er); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL mis_rdata got %h want 0", rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency got %0d want 1", lat); end
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_err got %b want 0", er); end
    checks++; if (rd !== 64'h0000000055667788) begin errors++; $display("FAIL mis_rdata got %h want 55667788", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency got %0d want 2", lat); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1, e2, r1, r2; logic ee; int el;
    int rsp1_k, rsp2_k, acc_k, busy_ready;
    bd_write(3, 64'h8877665544332211);
    bd_write(4, 64'h0123456789ABCDEF);
    model_req(1'b0, 2'd2, 1'b0, 8'h1C, 64'd0, e1, ee, el);
    model_req(1'b0, 2'd0, 1'b1, 8'h23, 64'd0, e2, ee, el);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 8'h1C; req_wdata = '0;
    @(posedge clk); #1;
    req_size = 2'd0; req_unsigned = 1'b1; req_addr = 8'h23;
    rsp1_k = -1; rsp2_k = -1; acc_k = -1; busy_ready = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp1_k < 0) begin rsp1_k = k; r1 = rsp_rdata; end
      else if (rsp_valid && acc_k > 0 && rsp2_k < 0) begin rsp2_k = k; r2 = rsp_rdata; end
      if (acc_k < 0 && k < 3 && req_ready) busy_ready++;
      if (acc_k < 0 && req_ready) begin
        acc_k = k;
        @(posedge clk); #1;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (rsp1_k !== 2) begin errors++; $display("FAIL b2b_rsp1 got cycle %0d want 2", rsp1_k); end
    checks++; if (busy_ready !== 0) begin errors++; $display("FAIL b2b_ready_busy got %0d high cycles want 0", busy_ready); end
    checks++; if (acc_k !== 3) begin errors++; $display("FAIL b2b_accept2 got cycle %0d want 3", acc_k); end
    checks++; if (rsp2_k !== 5) begin errors++; $display("FAIL b2b_rsp2 got cycle %0d want 5", rsp2_k); end
    checks++; if (r1 !== e1) begin errors++; $display("FAIL b2b_rdata1 got %h want %h", r1, e1); end
    checks++; if (r2 !== e2) begin errors++; $display("FAIL b2b_rdata2 got %h want %h", r2, e2); end
  endtask

  task automatic test_random();
    int lat, wc, elat, ewc; logic [63:0] rd, din, erd; logic er, eer, rok;
    logic [ADDR_W-1:0] wa; logic we, uns; logic [1:0] sz; logic [7:0] ad; logic [63:0] wd;
    for (int n = 0; n < 150; n++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 8'($urandom_range(0, 255));
      wd = {$urandom, $urandom};
      model_req(we, sz, uns, ad, wd, erd, eer, elat);
      ewc = (we && !eer) ? 1 : 0;
      run_req(we, sz, uns, ad, wd, lat, rd, er, wc, wa, din, rok);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, elat); end
      checks++; if (rd !== erd) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", n, rd, erd); end
      checks++; if (er !== eer) begin errors++; $display("FAIL rnd%0d_err got %b want %b", n, er, eer); end
      checks++; if (wc !== ewc) begin errors++; $display("FAIL rnd%0d_we_cycles got %0d want %0d", n, wc, ewc); end
      checks++; if (!rok) begin errors++; $display("FAIL rnd%0d_ready got high-while-busy want low", n); end
      if (ewc == 1) begin
        checks++; if (wa !== ad[7:3]) begin errors++; $display("FAIL rnd%0d_mem_addr got %0d want %0d", n, wa, ad[7:3]); end
        checks++; if (din !== ref_mem[ad[7:3]]) begin errors++; $display("FAIL rnd%0d_mem_din got %h want %h", n, din, ref_mem[ad[7:3]]); end
      end
    end
  endtask

  task automatic test_final_memory();
    @(negedge clk);
    for (int i = 0; i < NWORDS; i++) begin
      checks++;
      if (dmem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL mem_word%0d got %h want %h", i, dmem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < NWORDS; i++) bd_write(i, {$urandom, $urandom});
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_store_d();
    test_store_b_rmw();
    test_load_h_ext();
    test_reset_in_write();
    test_misaligned();
    test_back_to_back();
    test_random();
    test_final_memory();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
